bus_matrix: RTL and testbench
=============================

# bus_matrix

Parametrised shared-bus interconnect between `NUM_M` bus masters (core fetch port, core load/store port, future DMA) and `NUM_S` memory-mapped slaves (ROM, RAM, GPIO, timer, …). It arbitrates one transaction at a time under fixed-priority or round-robin policy and decodes the slave from the address top nibble. It runs a per-transaction handshake with wait-state support, a timeout and a decode-error response. It replaces the fixed two-master/three-slave combinational bus in `riscv_soc` and drives `bus_hold_flag_o` for pipeline stalls.

## Interface
- `NUM_M`, 2, number of masters (1–8); index 0 is highest fixed priority
- `NUM_S`, 4, number of slaves (1–16); slave k owns addresses `k<<28` .. `(k<<28)+0x0FFFFFFF`
- `ADDR_W`, 32, address width; slave select = `addr[ADDR_W-1:ADDR_W-4]`
- `DATA_W`, 32, data width
- `ARB_MODE`, 1, 0 = fixed priority, 1 = round-robin
- `TIMEOUT`, 16, max ACCESS cycles without `s_ack_i`; 0 disables timeout

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `m_req_i`  in  NUM_M  per-master request; held until granted
- `m_we_i`  in  NUM_M  1 = write
- `m_addr_i`  in  NUM_M*ADDR_W  flattened, master i at `[i*ADDR_W +: ADDR_W]`
- `m_wdata_i`  in  NUM_M*DATA_W  flattened write data
- `m_gnt_o`  out  NUM_M  one-hot grant pulse; request captured this cycle
- `m_rvalid_o`  out  NUM_M  one-hot one-cycle completion pulse
- `m_err_o`  out  1  error qualifier, valid with any `m_rvalid_o`
- `m_rdata_o`  out  DATA_W  shared read data, valid with `m_rvalid_o`
- `s_req_o`  out  NUM_S  one-hot slave request, held through ACCESS
- `s_we_o`  out  1  shared write enable
- `s_addr_o`  out  ADDR_W  shared registered address
- `s_wdata_o`  out  DATA_W  shared registered write data
- `s_rdata_i`  in  NUM_S*DATA_W  flattened slave read data
- `s_ack_i`  in  NUM_S  slave completion; rdata valid same cycle
- `bus_hold_flag_o`  out  1  `|(m_req_i & ~m_gnt_o)`

## Operation
- FSM states IDLE, ACCESS, RESP; reset state IDLE.
- IDLE: if any `m_req_i`, arbiter picks winner g; `m_gnt_o[g]`=1 combinationally; latch g, we, addr, wdata, sel. If sel < NUM_S go ACCESS, else RESP with err=1.
- ACCESS: `s_req_o[sel]`=1. On `s_ack_i[sel]`: capture `s_rdata_i[sel]` (writes capture 0), err=0, go RESP. Acks from non-selected slaves are ignored. Timeout counter starts at 0 on entry; at count TIMEOUT-1 with no ack, go RESP with err=1, rdata=0.
- RESP: `m_rvalid_o[g]`=1, `m_rdata_o`/`m_err_o` driven from registers; next state IDLE. No grant issued in ACCESS or RESP.
- Fixed priority: lowest requesting index wins.
- Round-robin: search starts at `last+1 mod NUM_M`; `last` updates on each grant; reset `last`=NUM_M-1 so master 0 wins first.
- Master dropping `m_req_i` before grant: no transaction, no state change.
- Write completion also pulses `m_rvalid_o` (rdata=0).

## Timing
- Reset (asynchronous, active-low): state IDLE, all `*_o` 0, latched registers 0, counter 0; in-flight transaction aborted, `s_req_o` drops immediately, no `m_rvalid_o` issued.
- Zero-wait slave: grant cycle 0, ACCESS cycle 1 (ack), `m_rvalid_o` cycle 2. Each wait state adds one cycle.
- Decode error: grant cycle 0, `m_rvalid_o`+`m_err_o` cycle 1.
- Timeout: `m_rvalid_o`+`m_err_o` exactly TIMEOUT+1 cycles after grant.
- Back-to-back: next grant earliest in the cycle after RESP (3-cycle throughput).
- `m_gnt_o`, `bus_hold_flag_o` combinational from `m_req_i` and state; all other outputs registered.

## Structure
- Shared package/defines: FSM state encoding, `SEL_MSB`/`SEL_LSB`, `ZERO_WORD`, ARB_MODE constants.
- One sub-module: `bus_rr_arbiter` (parametrised NUM_M, ARB_MODE; inputs req, advance; outputs one-hot gnt, encoded index).
- FSM, latch registers, timeout counter and read mux in `bus_matrix`.

## Test plan
- Reset: drive `rst`=0 mid-ACCESS -> all outputs 0 that cycle, no `m_rvalid_o` after release, next request granted normally.
- Single read, master 1 addr 0x1000_0040, slave 1 acks cycle 1 with 0xDEAD_BEEF -> `m_rvalid_o`=2'b10, `m_rdata_o`=0xDEAD_BEEF, err=0 at cycle 2.
- Wait states: slave 0 acks after 3 cycles -> `m_rvalid_o` at cycle 5 after grant; `s_req_o[0]` held cycles 1–4.
- Round-robin, both masters requesting continuously -> grants alternate 0,1,0,1; hold flag high every cycle the other is waiting; ARB_MODE=0 -> master 0 always wins.
- Decode error, addr 0xF000_0000 with NUM_S=4 -> `m_rvalid_o`+`m_err_o` at cycle 1, `s_req_o` never asserted.
- Timeout TIMEOUT=16, slave never acks -> `m_err_o`=1, rdata 0 at cycle 17; bus returns to IDLE and serves next request.

Source files
------------

// File: rtl/bus_matrix_pkg.sv
// Shared definitions for the bus_matrix interconnect: FSM encoding, slave-select
// field helpers, arbitration mode constants.
package bus_matrix_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } bus_state_e;

    // Slave select is the top nibble of the address.
    localparam int unsigned SEL_W = 4;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    localparam logic [63:0] ZERO_WORD = '0;

    function automatic int unsigned sel_msb(input int unsigned addr_w);
        return addr_w - 1;
    endfunction

    function automatic int unsigned sel_lsb(input int unsigned addr_w);
        return addr_w - SEL_W;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Request arbiter: fixed priority (lowest index wins) or round-robin starting
// after the most recent winner.
module bus_rr_arbiter
    import bus_matrix_pkg::*;
#(
    parameter int unsigned NUM_M    = 2,
    parameter int unsigned ARB_MODE = ARB_RR,
    parameter int unsigned IDX_W    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] req,
    input  logic             advance,
    output logic [NUM_M-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] last_q;

    always_comb begin
        int unsigned cand;
        logic        found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (ARB_MODE == ARB_RR) begin
                cand = 32'(last_q) + 1 + k;
                if (cand >= NUM_M) begin
                    cand = cand - NUM_M;
                end
            end else begin
                cand = k;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand[IDX_W-1:0];
            end
        end
    end

    // Reset to the last index so master 0 is first in round-robin order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= IDX_W'(NUM_M - 1);
        end else if (advance && (|req)) begin
            last_q <= idx;
        end
    end

endmodule

// File: rtl/bus_matrix.sv
// Shared-bus interconnect: one transaction at a time from NUM_M masters to
// NUM_S address-decoded slaves, with wait states, timeout and decode error.
module bus_matrix
    import bus_matrix_pkg::*;
#(
    parameter int unsigned NUM_M    = 2,
    parameter int unsigned NUM_S    = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARB_MODE = 1,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_req_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_M*DATA_W-1:0] m_wdata_i,
    output logic [NUM_M-1:0]        m_gnt_o,
    output logic [NUM_M-1:0]        m_rvalid_o,
    output logic                    m_err_o,
    output logic [DATA_W-1:0]       m_rdata_o,
    output logic [NUM_S-1:0]        s_req_o,
    output logic                    s_we_o,
    output logic [ADDR_W-1:0]       s_addr_o,
    output logic [DATA_W-1:0]       s_wdata_o,
    input  logic [NUM_S*DATA_W-1:0] s_rdata_i,
    input  logic [NUM_S-1:0]        s_ack_i,
    output logic                    bus_hold_flag_o
);

    localparam int unsigned IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SEL_MSB = sel_msb(ADDR_W);
    localparam int unsigned SEL_LSB = sel_lsb(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    bus_state_e        state_q, state_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [NUM_S-1:0]  sreq_q, sreq_d;
    logic [NUM_M-1:0]  rvalid_q, rvalid_d;

    logic [NUM_M-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [SEL_W-1:0]  win_sel;
    logic              ack_sel;
    logic [DATA_W-1:0] rdata_sel;

    bus_rr_arbiter #(
        .NUM_M   (NUM_M),
        .ARB_MODE(ARB_MODE),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (m_req_i),
        .advance(state_q == StIdle),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (arb_gnt[k]) begin
                win_we    = m_we_i[k];
                win_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
                win_wdata = m_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign win_sel = win_addr[SEL_MSB:SEL_LSB];

    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int unsigned k = 0; k < NUM_S; k++) begin
            if (sel_q == SEL_W'(k)) begin
                ack_sel   = s_ack_i[k];
                rdata_sel = s_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gidx_d   = gidx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        sreq_d   = sreq_q;
        rvalid_d = '0;
        case (state_q)
            StIdle: begin
                if (|m_req_i) begin
                    gidx_d  = arb_idx;
                    we_d    = win_we;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    sel_d   = win_sel;
                    cnt_d   = '0;
                    if (32'(win_sel) < NUM_S) begin
                        state_d = StAccess;
                        for (int unsigned k = 0; k < NUM_S; k++) begin
                            sreq_d[k] = (win_sel == SEL_W'(k));
                        end
                    end else begin
                        state_d  = StResp;
                        err_d    = 1'b1;
                        rdata_d  = ZERO_WORD[DATA_W-1:0];
                        rvalid_d = arb_gnt;
                    end
                end
            end
            StAccess: begin
                if (ack_sel || ((TIMEOUT != 0) && (cnt_q == CNT_LAST))) begin
                    state_d = StResp;
                    sreq_d  = '0;
                    err_d   = !ack_sel;
                    rdata_d = (ack_sel && !we_q) ? rdata_sel : ZERO_WORD[DATA_W-1:0];
                    for (int unsigned k = 0; k < NUM_M; k++) begin
                        rvalid_d[k] = (gidx_q == IDX_W'(k));
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            gidx_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            sreq_q   <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            sreq_q   <= sreq_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign m_gnt_o         = (rst && (state_q == StIdle)) ? arb_gnt : '0;
    assign bus_hold_flag_o = rst && (|(m_req_i & ~m_gnt_o));

    assign m_rvalid_o = rvalid_q;
    assign m_err_o    = err_q;
    assign m_rdata_o  = rdata_q;
    assign s_req_o    = sreq_q;
    assign s_we_o     = we_q;
    assign s_addr_o   = addr_q;
    assign s_wdata_o  = wdata_q;

endmodule

// File: tb/tb_bus_matrix.sv
// Directed bench for bus_matrix: scoreboard of expected responses, immediate
// assertions at every comparison point.
module tb_bus_matrix;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   m_req;
    logic [1:0]   m_we;
    logic [63:0]  m_addr;
    logic [63:0]  m_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   ack_man;
    logic         auto_ack;

    wire [1:0]  m_gnt, m_rvalid;
    wire        m_err, s_we, hold;
    wire [31:0] m_rdata, s_addr, s_wdata;
    wire [3:0]  s_req, s_ack;

    wire [1:0]  f_gnt, f_rvalid;
    wire        f_err, f_we, f_hold;
    wire [31:0] f_rdata, f_addr, f_wdata;
    wire [3:0]  f_req;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned m;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign s_ack = auto_ack ? s_req : ack_man;

    bus_matrix #(
        .NUM_M(2), .NUM_S(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(16)
    ) u_dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_err_o(m_err), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .s_ack_i(s_ack), .bus_hold_flag_o(hold)
    );

    // Fixed-priority instance with zero-wait slaves on the same master inputs.
    bus_matrix #(
        .NUM_M(2), .NUM_S(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(16)
    ) u_fix (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_gnt_o(f_gnt), .m_rvalid_o(f_rvalid), .m_err_o(f_err), .m_rdata_o(f_rdata),
        .s_req_o(f_req), .s_we_o(f_we), .s_addr_o(f_addr), .s_wdata_o(f_wdata),
        .s_rdata_i(s_rdata), .s_ack_i(f_req), .bus_hold_flag_o(f_hold)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int unsigned m, input logic [31:0] data, input logic err);
        exp_t e;
        e.m    = m;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rvalid"}, 64'(m_rvalid), 64'(1) << e.m);
            chk({tag, "_rdata"}, 64'(m_rdata), 64'(e.data));
            chk({tag, "_err"}, 64'(m_err), 64'(e.err));
        end
    endtask

    initial begin
        m_req    = '0;
        m_we     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        s_rdata  = '0;
        ack_man  = '0;
        auto_ack = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_sreq", 64'(s_req), 64'(0));
        chk("rst_rvalid", 64'(m_rvalid), 64'(0));
        chk("rst_err", 64'(m_err), 64'(0));
        chk("rst_rdata", 64'(m_rdata), 64'(0));
        chk("rst_saddr", 64'(s_addr), 64'(0));
        chk("rst_gnt", 64'(m_gnt), 64'(0));
        chk("rst_hold", 64'(hold), 64'(0));
        rst = 1'b1;
        tick();

        // Single read: master 1 -> slave 1, zero wait
        s_rdata[32 +: 32] = 32'hDEAD_BEEF;
        m_addr[32 +: 32]  = 32'h1000_0040;
        m_req             = 2'b10;
        #1;
        chk("rd_gnt", 64'(m_gnt), 64'(2'b10));
        chk("rd_hold", 64'(hold), 64'(0));
        push(1, 32'hDEAD_BEEF, 1'b0);
        tick();
        m_req = 2'b00;
        chk("rd_sreq", 64'(s_req), 64'(4'b0010));
        chk("rd_saddr", 64'(s_addr), 64'(32'h1000_0040));
        chk("rd_swe", 64'(s_we), 64'(0));
        chk("rd_rv_early", 64'(m_rvalid), 64'(0));
        ack_man = 4'b0010;
        tick();
        ack_man = 4'b0000;
        pop_check("rd");
        chk("rd_sreq_off", 64'(s_req), 64'(0));
        tick();
        chk("rd_rv_once", 64'(m_rvalid), 64'(0));

        // Wait states: master 0 -> slave 0, ack in cycle 4; stray ack from slave 2
        s_rdata[0 +: 32] = 32'h1234_5678;
        m_addr[0 +: 32]  = 32'h0000_0100;
        m_req            = 2'b01;
        #1;
        chk("ws_gnt", 64'(m_gnt), 64'(2'b01));
        push(0, 32'h1234_5678, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            m_req = 2'b00;
            chk($sformatf("ws_sreq_c%0d", c), 64'(s_req), 64'(4'b0001));
            chk($sformatf("ws_rv_c%0d", c), 64'(m_rvalid), 64'(0));
            ack_man = (c == 4) ? 4'b0001 : ((c == 2) ? 4'b0100 : 4'b0000);
        end
        tick();
        ack_man = 4'b0000;
        pop_check("ws");
        tick();

        // Write: master 0 -> slave 3, completion returns zero data
        s_rdata[96 +: 32] = 32'hFFFF_FFFF;
        m_addr[0 +: 32]   = 32'h3000_0008;
        m_wdata[0 +: 32]  = 32'hA5A5_5A5A;
        m_we              = 2'b01;
        m_req             = 2'b01;
        #1;
        push(0, 32'h0, 1'b0);
        tick();
        m_req = 2'b00;
        m_we  = 2'b00;
        chk("wr_swe", 64'(s_we), 64'(1));
        chk("wr_swdata", 64'(s_wdata), 64'(32'hA5A5_5A5A));
        chk("wr_sreq", 64'(s_req), 64'(4'b1000));
        ack_man = 4'b1000;
        tick();
        ack_man = 4'b0000;
        pop_check("wr");
        tick();

        // Decode error: slave select 0xF with four slaves
        m_addr[0 +: 32] = 32'hF000_0000;
        m_req           = 2'b01;
        #1;
        chk("de_gnt", 64'(m_gnt), 64'(2'b01));
        push(0, 32'h0, 1'b1);
        tick();
        m_req = 2'b00;
        chk("de_sreq", 64'(s_req), 64'(0));
        pop_check("de");
        tick();
        chk("de_sreq_after", 64'(s_req), 64'(0));

        // Timeout: master 1 -> slave 2, never acked
        s_rdata[64 +: 32] = 32'h5555_5555;
        m_addr[32 +: 32]  = 32'h2000_0000;
        m_req             = 2'b10;
        #1;
        chk("to_gnt", 64'(m_gnt), 64'(2'b10));
        push(1, 32'h0, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            m_req = 2'b00;
            chk($sformatf("to_sreq_c%0d", c), 64'(s_req), 64'(4'b0100));
            chk($sformatf("to_rv_c%0d", c), 64'(m_rvalid), 64'(0));
        end
        tick();
        pop_check("to");
        tick();
        m_addr[0 +: 32] = 32'h1000_0000;
        m_req           = 2'b01;
        #1;
        chk("to_next_gnt", 64'(m_gnt), 64'(2'b01));
        push(0, 32'hDEAD_BEEF, 1'b0);
        tick();
        m_req   = 2'b00;
        ack_man = 4'b0010;
        tick();
        ack_man = 4'b0000;
        pop_check("to_next");
        tick();

        // Reset in the middle of ACCESS
        m_addr[0 +: 32] = 32'h2000_0004;
        m_req           = 2'b01;
        tick();
        m_req = 2'b00;
        chk("ra_sreq_pre", 64'(s_req), 64'(4'b0100));
        rst = 1'b0;
        #1;
        chk("ra_sreq", 64'(s_req), 64'(0));
        chk("ra_rvalid", 64'(m_rvalid), 64'(0));
        chk("ra_err", 64'(m_err), 64'(0));
        chk("ra_rdata", 64'(m_rdata), 64'(0));
        chk("ra_saddr", 64'(s_addr), 64'(0));
        chk("ra_gnt", 64'(m_gnt), 64'(0));
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ra_norv_c%0d", c), 64'(m_rvalid), 64'(0));
        end
        m_addr[32 +: 32] = 32'h1000_0008;
        m_req            = 2'b10;
        #1;
        chk("ra_next_gnt", 64'(m_gnt), 64'(2'b10));
        push(1, 32'hDEAD_BEEF, 1'b0);
        tick();
        m_req   = 2'b00;
        ack_man = 4'b0010;
        tick();
        ack_man = 4'b0000;
        pop_check("ra_next");
        tick();

        // Both masters requesting continuously: round-robin vs fixed priority
        s_rdata[0 +: 32] = 32'h0000_0A0A;
        m_addr           = {32'h1000_0020, 32'h0000_0010};
        m_we             = 2'b00;
        auto_ack         = 1'b1;
        m_req            = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_gnt_%0d", k), 64'(m_gnt), (k % 2 == 0) ? 64'(1) : 64'(2));
            chk($sformatf("rr_hold_g%0d", k), 64'(hold), 64'(1));
            chk($sformatf("fix_gnt_%0d", k), 64'(f_gnt), 64'(1));
            chk($sformatf("fix_hold_%0d", k), 64'(f_hold), 64'(1));
            push(k % 2, (k % 2 == 1) ? 32'hDEAD_BEEF : 32'h0000_0A0A, 1'b0);
            tick();
            chk($sformatf("rr_hold_a%0d", k), 64'(hold), 64'(1));
            tick();
            pop_check($sformatf("rr_%0d", k));
            chk($sformatf("rr_hold_r%0d", k), 64'(hold), 64'(1));
            chk($sformatf("fix_rvalid_%0d", k), 64'(f_rvalid), 64'(1));
            tick();
        end
        m_req    = 2'b00;
        auto_ack = 1'b0;
        tick();
        tick();
        chk("end_sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
